// File: rtl/fifo_pkg.sv
// Shared helpers for fifo_stream: pointer width and parameter legality checks.
// Used by fifo_stream and fifo_ram.
package fifo_pkg;

  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic bit depth_legal(input int depth);
    return (depth >= 4) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit afull_legal(input int thresh, input int depth);
    return (thresh >= 1) && (thresh <= depth);
  endfunction

  function automatic bit aempty_legal(input int thresh, input int depth);
    return (thresh >= 0) && (thresh <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_stream_if.sv
// Stream/status bundle for fifo_stream. The error ports exist only when
// FIFO_STREAM_ERR_EN is defined.
interface fifo_stream_if #(
  parameter int DEPTH      = 256,
  parameter int DATA_WIDTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  we;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  re;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  empty;
  logic                  full;
  logic                  aempty;
  logic                  afull;
  logic [CW-1:0]         count;
`ifdef FIFO_STREAM_ERR_EN
  logic                  overflow;
  logic                  underflow;
  logic                  clr_err;
`endif

  modport master (
    output we, w_data, re,
    input  r_data, r_valid, empty, full, aempty, afull, count
`ifdef FIFO_STREAM_ERR_EN
    , output clr_err, input overflow, underflow
`endif
  );

  modport slave (
    input  we, w_data, re,
    output r_data, r_valid, empty, full, aempty, afull, count
`ifdef FIFO_STREAM_ERR_EN
    , input clr_err, output overflow, underflow
`endif
  );

endinterface

// File: rtl/fifo_ram.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one asynchronous
// read port.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int DATA_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [fifo_ptr_w(DEPTH)-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0]        w_data,
  input  logic [fifo_ptr_w(DEPTH)-1:0] r_addr,
  output logic [DATA_WIDTH-1:0]        r_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; a reset branch would stop it mapping to RAM,
  // and the pointers already guarantee stale words are never presented.
  always_ff @(posedge clk) begin
    if (we) mem[w_addr] <= w_data;
  end

  assign r_data = mem[r_addr];

endmodule

// File: rtl/fifo_stream.sv
// Synchronous FIFO with registered-read or FWFT output, occupancy count and
// threshold flags. Define FIFO_STREAM_ERR_EN for sticky overflow/underflow.
module fifo_stream
  import fifo_pkg::*;
#(
  parameter int DEPTH         = 256,
  parameter int DATA_WIDTH    = 8,
  parameter int AFULL_THRESH  = DEPTH - 4,
  parameter int AEMPTY_THRESH = 4,
  parameter int FWFT          = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  fifo_stream_if.slave  bus
);

  localparam int PW = fifo_ptr_w(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam logic [CW-1:0] AF_CNT   = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AE_CNT   = CW'(AEMPTY_THRESH);

  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $error("fifo_stream: DEPTH must be a power of two >= 4");
  end
  if (!afull_legal(AFULL_THRESH, DEPTH)) begin : g_bad_afull
    $error("fifo_stream: AFULL_THRESH out of range 1..DEPTH");
  end
  if (!aempty_legal(AEMPTY_THRESH, DEPTH)) begin : g_bad_aempty
    $error("fifo_stream: AEMPTY_THRESH out of range 0..DEPTH-1");
  end

  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] r_data_q, ram_rdata, head_next;
  logic                  r_valid_q;
  logic                  empty, full;
  logic                  wr_acc, rd_acc, mem_we, pop_mem, load_head, bypass;

  assign empty  = (cnt == '0);
  assign full   = (cnt == FULL_CNT);
  assign wr_acc = bus.we && !full;
  assign rd_acc = bus.re && !empty;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    bypass    = 1'b0;
    mem_we    = wr_acc;
    pop_mem   = rd_acc;
    load_head = rd_acc;
    if (FWFT != 0) begin
      // In FWFT the head lives in r_data_q, so memory holds count-1 words;
      // a write that would become the head skips memory entirely.
      bypass    = wr_acc && (empty || (cnt == ONE_CNT && rd_acc));
      mem_we    = wr_acc && !bypass;
      pop_mem   = rd_acc && (cnt > ONE_CNT);
      load_head = bypass || pop_mem;
    end
  end

  assign head_next = bypass ? bus.w_data : ram_rdata;

  fifo_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk    (clk),
    .we     (mem_we),
    .w_addr (wr_ptr),
    .w_data (bus.w_data),
    .r_addr (rd_ptr),
    .r_data (ram_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
    end else begin
      if (mem_we)    wr_ptr   <= wr_ptr + 1'b1;
      if (pop_mem)   rd_ptr   <= rd_ptr + 1'b1;
      if (load_head) r_data_q <= head_next;
      r_valid_q <= rd_acc;
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + ONE_CNT;
        2'b01:   cnt <= cnt - ONE_CNT;
        default: cnt <= cnt;
      endcase
    end
  end

  assign bus.r_data  = r_data_q;
  assign bus.r_valid = (FWFT != 0) ? !empty : r_valid_q;
  assign bus.empty   = empty;
  assign bus.full    = full;
  assign bus.aempty  = (cnt <= AE_CNT);
  assign bus.afull   = (cnt >= AF_CNT);
  assign bus.count   = cnt;

`ifdef FIFO_STREAM_ERR_EN
  logic overflow_q, underflow_q;

  // A set condition beats clr_err in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.we && full)        overflow_q  <= 1'b1;
      else if (bus.clr_err)      overflow_q  <= 1'b0;
      if (bus.re && empty)       underflow_q <= 1'b1;
      else if (bus.clr_err)      underflow_q <= 1'b0;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif

endmodule
